// File: rtl/usb_host_auth_responder_if.sv
// Request/response bus between the host sequencer, the authentication
// driver and the host-side auth responder. The slave modport is the
// responder's view; the master modport is the sequencer/driver view.
interface usb_host_auth_responder_if #(
    parameter int MSG_LEN   = 2080,
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    // Push channel from the host sequencer
    logic                push_valid;
    logic                push_ready;
    logic [SLOT_W-1:0]   push_slot;
    logic [1:0]          push_type;
    logic [MSG_LEN-1:0]  push_msg;

    // Request/response handshake with the authentication driver
    logic                resp_req_in;
    logic                resp_req_out;
    logic [MSG_LEN-1:0]  auth_msg_in;
    logic                auth_msg_ready;
    logic [MSG_LEN-1:0]  auth_msg_out;
    logic                Ack_in_driver;

    modport slave (
        input  push_valid, push_slot, push_type, push_msg,
        output push_ready,
        output resp_req_in, auth_msg_in, Ack_in_driver,
        input  resp_req_out, auth_msg_ready, auth_msg_out
    );

    modport master (
        output push_valid, push_slot, push_type, push_msg,
        input  push_ready,
        input  resp_req_in, auth_msg_in, Ack_in_driver,
        output resp_req_out, auth_msg_ready, auth_msg_out
    );
endinterface

// File: rtl/usb_host_auth_responder.sv
// Host-side partner for the authentication driver: queues requests from the
// sequencer, tracks the pending request type per slot, hands each queued
// message to the driver, captures the response and acknowledges it. Also
// drives CC1/CC2 attach signalling with selectable plug orientation.
module usb_host_auth_responder #(
    parameter int MSG_LEN   = 2080,
    parameter int NUM_SLOTS = 4,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    usb_host_auth_responder_if.slave      bus,
    output logic [2*NUM_SLOTS-1:0]        pending_auth_request,
    output logic                          rsp_valid,
    output logic [MSG_LEN-1:0]            rsp_msg,
    output logic [$clog2(NUM_SLOTS)-1:0]  rsp_slot,
    output logic                          timeout_err,
    input  logic                          attach,
    input  logic                          flip,
    output logic                          CC1,
    output logic                          CC2
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DCNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE   = WCNT_W'(1);
    localparam logic [DCNT_W-1:0] DLY_LAST   = DCNT_W'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
    localparam logic [DCNT_W-1:0] DLY_ONE    = DCNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_ACK_DLY  = 3'd3,
        ST_ACK      = 3'd4
    } state_t;

    // Request FIFO storage and bookkeeping
    logic [MSG_LEN-1:0]   msg_mem_r [DEPTH];
    logic [SLOT_W-1:0]    slot_mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic [PTR_W:0]       count_next_s;
    logic                 push_ready_r;

    // Transaction FSM state and registered outputs
    state_t               state_r;
    logic [WCNT_W-1:0]    wait_cnt_r;
    logic [DCNT_W-1:0]    dly_cnt_r;
    logic                 resp_req_r;
    logic                 ack_r;
    logic                 rsp_valid_r;
    logic [MSG_LEN-1:0]   rsp_msg_r;
    logic [SLOT_W-1:0]    rsp_slot_r;
    logic                 timeout_err_r;

    logic [NUM_SLOTS-1:0][1:0] pending_r;
    logic                 cc1_r;
    logic                 cc2_r;

    // Decoded control
    logic                 push_fire_s;
    logic                 push_en_s;
    logic                 fifo_empty_s;
    logic [SLOT_W-1:0]    head_slot_s;
    logic                 wait_expire_s;
    logic                 pop_s;
    logic                 clr_en_s;
    logic [SLOT_W-1:0]    clr_slot_s;

    // A type-00 push is handshaken but leaves no trace in the queue or pending map
    assign push_fire_s   = bus.push_valid && push_ready_r;
    assign push_en_s     = push_fire_s && (bus.push_type != 2'b00);
    assign fifo_empty_s  = (count_r == '0);
    assign head_slot_s   = slot_mem_r[rd_ptr_r];
    // Ready on the final WAIT_RDY cycle takes precedence over the timeout
    assign wait_expire_s = (state_r == ST_WAIT_RDY) && !bus.auth_msg_ready
                           && (wait_cnt_r == WAIT_LAST);
    assign pop_s         = (state_r == ST_ACK) || wait_expire_s;

    // Occupancy after this cycle's push/pop; push_ready is registered from it
    always_comb begin
        count_next_s = count_r;
        case ({push_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Slot whose pending entry retires this cycle (ACK or timeout)
    always_comb begin
        clr_en_s   = 1'b0;
        clr_slot_s = head_slot_s;
        if (state_r == ST_ACK) begin
            clr_en_s   = 1'b1;
            clr_slot_s = rsp_slot_r;
        end else if (wait_expire_s) begin
            clr_en_s   = 1'b1;
            clr_slot_s = head_slot_s;
        end else begin
            clr_en_s   = 1'b0;
            clr_slot_s = head_slot_s;
        end
    end

    // FIFO payload write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            msg_mem_r[wr_ptr_r]  <= bus.push_msg;
            slot_mem_r[wr_ptr_r] <= bus.push_slot;
        end
    end

    // FIFO pointers, occupancy and registered push_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            push_ready_r <= 1'b1;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r      <= count_next_s;
            push_ready_r <= (count_next_s != FULL_COUNT);
        end
    end

    // Per-slot pending map; a same-cycle push overrides a retiring clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            if (clr_en_s) begin
                pending_r[clr_slot_s] <= 2'b00;
            end
            if (push_en_s) begin
                pending_r[bus.push_slot] <= bus.push_type;
            end
        end
    end

    // Transaction FSM: IDLE -> REQ -> WAIT_RDY -> [ACK_DLY] -> ACK -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= '0;
            dly_cnt_r     <= '0;
            resp_req_r    <= 1'b0;
            ack_r         <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_msg_r     <= '0;
            rsp_slot_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            ack_r         <= 1'b0;
            rsp_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r    <= ST_REQ;
                        resp_req_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.resp_req_out) begin
                        state_r    <= ST_WAIT_RDY;
                        resp_req_r <= 1'b0;
                        wait_cnt_r <= '0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (bus.auth_msg_ready) begin
                        rsp_msg_r  <= bus.auth_msg_out;
                        rsp_slot_r <= head_slot_s;
                        dly_cnt_r  <= '0;
                        if (ACK_DELAY == 0) begin
                            state_r     <= ST_ACK;
                            ack_r       <= 1'b1;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_ACK_DLY;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_ACK_DLY: begin
                    if (dly_cnt_r == DLY_LAST) begin
                        state_r     <= ST_ACK;
                        ack_r       <= 1'b1;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + DLY_ONE;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_req_r <= 1'b0;
                end
            endcase
        end
    end

    // CC attach signalling with plug orientation, one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            cc1_r <= 1'b0;
            cc2_r <= 1'b0;
        end else begin
            cc1_r <= attach & ~flip;
            cc2_r <= attach & flip;
        end
    end

    assign bus.push_ready     = push_ready_r;
    assign bus.resp_req_in    = resp_req_r;
    assign bus.auth_msg_in    = fifo_empty_s ? '0 : msg_mem_r[rd_ptr_r];
    assign bus.Ack_in_driver  = ack_r;
    assign pending_auth_request = pending_r;
    assign rsp_valid          = rsp_valid_r;
    assign rsp_msg            = rsp_msg_r;
    assign rsp_slot           = rsp_slot_r;
    assign timeout_err        = timeout_err_r;
    assign CC1                = cc1_r;
    assign CC2                = cc2_r;
endmodule

// File: tb/tb_usb_host_auth_responder.sv
// Directed bench for usb_host_auth_responder: the main process issues pushes
// and records the expected responses in a scoreboard queue, a driver model
// answers the resp_req handshake, and a monitor pops and compares whenever
// the DUT emits rsp_valid or timeout_err.
module tb_usb_host_auth_responder;
    localparam int MSG_LEN   = 2080;
    localparam int NUM_SLOTS = 4;
    localparam int DEPTH     = 4;
    localparam int ACK_DELAY = 2;
    localparam int TIMEOUT   = 16;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    typedef struct {
        bit                  is_timeout;
        logic [SLOT_W-1:0]   slot;
        logic [MSG_LEN-1:0]  msg;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [2*NUM_SLOTS-1:0]  pending_auth_request;
    logic                    rsp_valid;
    logic [MSG_LEN-1:0]      rsp_msg;
    logic [SLOT_W-1:0]       rsp_slot;
    logic                    timeout_err;
    logic                    attach;
    logic                    flip;
    logic                    CC1;
    logic                    CC2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t               exp_q[$];
    logic [MSG_LEN-1:0] drv_resp_q[$];
    bit                 drv_never = 1'b0;
    int                 drv_delay = 3;
    int                 drv_acc_cyc = 0;
    int                 drv_rdy_cyc = 0;

    usb_host_auth_responder_if #(.MSG_LEN(MSG_LEN), .NUM_SLOTS(NUM_SLOTS)) bus ();

    usb_host_auth_responder #(
        .MSG_LEN(MSG_LEN), .NUM_SLOTS(NUM_SLOTS), .DEPTH(DEPTH),
        .ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pending_auth_request(pending_auth_request),
        .rsp_valid(rsp_valid),
        .rsp_msg(rsp_msg),
        .rsp_slot(rsp_slot),
        .timeout_err(timeout_err),
        .attach(attach),
        .flip(flip),
        .CC1(CC1),
        .CC2(CC2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MSG_LEN-1:0] mk_msg(input logic [7:0] hi, input logic [15:0] lo);
        logic [MSG_LEN-1:0] m;
        m = '0;
        m[15:0] = lo;
        m[MSG_LEN-1 -: 8] = hi;
        return m;
    endfunction

    function automatic exp_t mk_exp(input bit t, input logic [SLOT_W-1:0] s, input logic [MSG_LEN-1:0] m);
        exp_t e;
        e.is_timeout = t;
        e.slot = s;
        e.msg = m;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_msg(input string name, input logic [MSG_LEN-1:0] act, input logic [MSG_LEN-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got hi32=0x%h lo32=0x%h, expected hi32=0x%h lo32=0x%h",
                     name, act[MSG_LEN-1 -: 32], act[31:0], req[MSG_LEN-1 -: 32], req[31:0]);
        end
    endtask

    task automatic drive_push(input logic [SLOT_W-1:0] s, input logic [1:0] t, input logic [MSG_LEN-1:0] m);
        bus.push_valid = 1'b1;
        bus.push_slot  = s;
        bus.push_type  = t;
        bus.push_msg   = m;
    endtask

    task automatic idle_push();
        bus.push_valid = 1'b0;
        bus.push_type  = 2'b00;
    endtask

    // Waits (at negedges) until resp_req_in is seen, bounded by lim cycles
    task automatic wait_req(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (bus.resp_req_in) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits until the scoreboard is empty, then lets the FSM settle
    task automatic wait_drain(input string name, input int lim);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, {63'd0, ok}, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Driver model: accepts each request with a one-cycle resp_req_out pulse,
    // then after drv_delay cycles presents the next queued response
    initial begin
        int phase;
        int wcnt;
        phase = 0;
        wcnt  = 0;
        bus.resp_req_out   = 1'b0;
        bus.auth_msg_ready = 1'b0;
        bus.auth_msg_out   = '0;
        forever begin
            @(negedge clk);
            bus.resp_req_out   = 1'b0;
            bus.auth_msg_ready = 1'b0;
            if (reset) begin
                phase = 0;
            end else if (phase == 0) begin
                if (bus.resp_req_in) begin
                    bus.resp_req_out = 1'b1;
                    drv_acc_cyc = cyc;
                    wcnt = 0;
                    phase = drv_never ? 0 : 1;
                end
            end else begin
                wcnt++;
                if (wcnt >= drv_delay) begin
                    bus.auth_msg_ready = 1'b1;
                    bus.auth_msg_out = (drv_resp_q.size() > 0) ? drv_resp_q.pop_front() : '0;
                    drv_rdy_cyc = cyc;
                    phase = 0;
                end
            end
        end
    end

    // Monitor: every rsp_valid/timeout_err/Ack is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.Ack_in_driver || rsp_valid || timeout_err)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: rsp_valid=%0b timeout_err=%0b ack=%0b with empty scoreboard (cycle %0d)",
                             rsp_valid, timeout_err, bus.Ack_in_driver, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_timeout", {63'd0, timeout_err}, {63'd0, e.is_timeout});
                    check("ack_matches_rsp_valid", {63'd0, bus.Ack_in_driver}, {63'd0, rsp_valid});
                    if (e.is_timeout) begin
                        // timeout edge is TIMEOUT edges after the WAIT_RDY entry edge
                        check("timeout_latency", 64'(cyc - drv_acc_cyc), 64'(TIMEOUT + 1));
                    end else begin
                        check("rsp_slot", 64'(rsp_slot), 64'(e.slot));
                        check_msg("rsp_msg", rsp_msg, e.msg);
                        // ready is sampled one edge after it is driven, Ack follows ACK_DELAY edges later
                        check("ack_latency", 64'(cyc - drv_rdy_cyc), 64'(ACK_DELAY + 1));
                    end
                end
            end
        end
    end

    // Hard stop in case something wedges the bench
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSG_LEN-1:0] m;
        logic [MSG_LEN-1:0] r;
        logic [1:0]         types [4];
        int                 push_cyc;
        bit                 ok;

        reset  = 1'b1;
        attach = 1'b0;
        flip   = 1'b0;
        bus.push_slot = '0;
        bus.push_msg  = '0;
        idle_push();
        types[0] = 2'b01; types[1] = 2'b10; types[2] = 2'b11; types[3] = 2'b01;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_push_ready", {63'd0, bus.push_ready}, 64'd1);
        check("rst_resp_req_in", {63'd0, bus.resp_req_in}, 64'd0);
        check("rst_ack", {63'd0, bus.Ack_in_driver}, 64'd0);
        check("rst_pending", 64'(pending_auth_request), 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        check("rst_cc", {62'd0, CC1, CC2}, 64'd0);
        check_msg("rst_auth_msg_in", bus.auth_msg_in, '0);
        check_msg("rst_rsp_msg", rsp_msg, '0);
        reset = 1'b0;

        // ---- single push: slot 1, type 01, response 0xABCD ----
        @(negedge clk);
        m = mk_msg(8'h5A, 16'h0103);
        r = mk_msg(8'h00, 16'hABCD);
        exp_q.push_back(mk_exp(1'b0, 2'd1, r));
        drv_resp_q.push_back(r);
        push_cyc = cyc;
        drive_push(2'd1, 2'b01, m);
        @(negedge clk);
        idle_push();
        check("t1_pending_set", 64'(pending_auth_request), 64'b00_00_01_00);
        wait_req(10, ok);
        check("t1_req_seen", {63'd0, ok}, 64'd1);
        check("t1_req_latency", 64'(cyc - push_cyc), 64'd2);
        check_msg("t1_auth_msg_in", bus.auth_msg_in, m);
        wait_drain("t1_drain", 60);
        check("t1_pending_clear", 64'(pending_auth_request), 64'd0);

        // ---- fill four slots, fifth push dropped while full ----
        for (int i = 0; i < 4; i++) begin
            m = mk_msg(8'h10 + 8'(i), 16'h1000 + 16'(i));
            r = mk_msg(8'hE0 + 8'(i), 16'hC000 + 16'(i));
            exp_q.push_back(mk_exp(1'b0, SLOT_W'(i), r));
            drv_resp_q.push_back(r);
            drive_push(SLOT_W'(i), types[i], m);
            @(negedge clk);
        end
        check("t2_push_ready_full", {63'd0, bus.push_ready}, 64'd0);
        drive_push(2'd0, 2'b10, mk_msg(8'hFF, 16'hDEAD));
        @(negedge clk);
        idle_push();
        check("t2_pending_after_fill", 64'(pending_auth_request), 64'b01_11_10_01);
        for (int k = 0; k < 60 && exp_q.size() > 3; k++) @(negedge clk);
        @(negedge clk);
        check("t2_pending_slot0_cleared", 64'(pending_auth_request), 64'b01_11_10_00);
        wait_drain("t2_drain", 200);
        check("t2_pending_clear", 64'(pending_auth_request), 64'd0);
        check("t2_push_ready_again", {63'd0, bus.push_ready}, 64'd1);

        // ---- driver never answers: timeout on slot 3 ----
        drv_never = 1'b1;
        exp_q.push_back(mk_exp(1'b1, 2'd3, '0));
        drive_push(2'd3, 2'b10, mk_msg(8'h33, 16'h3333));
        @(negedge clk);
        idle_push();
        check("t3_pending_set", 64'(pending_auth_request), 64'b10_00_00_00);
        wait_drain("t3_drain", 60);
        check("t3_pending_clear", 64'(pending_auth_request), 64'd0);
        drv_never = 1'b0;

        // ---- push to slot 2 on the ACK cycle of a slot-2 transaction ----
        r = mk_msg(8'h22, 16'h2A2A);
        exp_q.push_back(mk_exp(1'b0, 2'd2, r));
        drv_resp_q.push_back(r);
        drive_push(2'd2, 2'b01, mk_msg(8'h21, 16'h2001));
        @(negedge clk);
        idle_push();
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Ack_in_driver) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_ack_seen", {63'd0, ok}, 64'd1);
        m = mk_msg(8'h2B, 16'h2B02);
        r = mk_msg(8'h2C, 16'h2C2C);
        exp_q.push_back(mk_exp(1'b0, 2'd2, r));
        drv_resp_q.push_back(r);
        drive_push(2'd2, 2'b11, m);
        @(negedge clk);
        idle_push();
        check("t4_pending_push_wins", 64'(pending_auth_request), 64'b00_11_00_00);
        wait_req(10, ok);
        check("t4_req_seen", {63'd0, ok}, 64'd1);
        check_msg("t4_next_auth_msg_in", bus.auth_msg_in, m);
        wait_drain("t4_drain", 60);
        check("t4_pending_clear", 64'(pending_auth_request), 64'd0);

        // ---- reset while in ACK_DLY: silent abandon ----
        drv_resp_q.push_back(mk_msg(8'h77, 16'h7777));
        drive_push(2'd0, 2'b11, mk_msg(8'h70, 16'h7000));
        @(negedge clk);
        idle_push();
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.auth_msg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_ready_seen", {63'd0, ok}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_push_ready", {63'd0, bus.push_ready}, 64'd1);
        check("t5_resp_req_in", {63'd0, bus.resp_req_in}, 64'd0);
        check("t5_ack", {63'd0, bus.Ack_in_driver}, 64'd0);
        check("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("t5_timeout_err", {63'd0, timeout_err}, 64'd0);
        check("t5_pending", 64'(pending_auth_request), 64'd0);
        check("t5_rsp_slot", 64'(rsp_slot), 64'd0);
        check_msg("t5_rsp_msg", rsp_msg, '0);
        check_msg("t5_auth_msg_in_empty", bus.auth_msg_in, '0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("t5_no_new_req", {63'd0, bus.resp_req_in}, 64'd0);

        // ---- CC attach/orientation ----
        attach = 1'b1;
        flip   = 1'b0;
        @(negedge clk);
        check("cc_attach_normal", {62'd0, CC1, CC2}, 64'b10);
        flip = 1'b1;
        @(negedge clk);
        check("cc_attach_flipped", {62'd0, CC1, CC2}, 64'b01);
        attach = 1'b0;
        @(negedge clk);
        check("cc_detached", {62'd0, CC1, CC2}, 64'b00);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
